// File: rtl/sa_result_writer_pkg.sv
// Shared constants and state encoding for the SA result write-back path.
// Defaults are shared with the weight address decoder and the SA top.
package sa_result_writer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int DIM_DEF    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sa_result_writer_if.sv
// Element stream in from the SA and the memory write bus out.
// The writer is the slave; the SA/memory side is the master.
interface sa_result_writer_if
  import sa_result_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/sa_result_writer_rowcol.sv
// Row/col walk for a column-major stream with an incremental
// row-major address (no multiplier) and a last-element flag.
module sa_rowcol_counter
  import sa_result_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base_in,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_elem
);

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] base;

  // Column wraps restart from base+col+1; rows stride by DIM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      base <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      base <= base_in;
      addr <= base_in;
    end else if (step) begin
      if (row == LAST) begin
        row  <= '0;
        col  <= col + 1'b1;
        addr <= base + ADDR_W'(col) + ADDR_W'(1);
      end else begin
        row  <= row + 1'b1;
        addr <= addr + ADDR_W'(DIM);
      end
    end
  end

  assign last_elem = (row == LAST) && (col == LAST);

endmodule

// File: rtl/sa_result_writer.sv
// Column-major SA result stream to row-major memory writer,
// one matrix per start.
module sa_result_writer
  import sa_result_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  sa_result_writer_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic              clear;
  logic              hs;
  logic              last_elem;
  logic [ADDR_W-1:0] cur_addr;

  sa_rowcol_counter #(
    .ADDR_W (ADDR_W),
    .DIM    (DIM)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .base_in   (base_addr),
    .step      (hs),
    .addr      (cur_addr),
    .last_elem (last_elem)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, counter control and handshake decode.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    hs       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear    = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        hs = bus.in_valid;
        if (hs && last_elem) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready = (state == WRITE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  // Registered write port; addr/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= hs;
      if (hs) begin
        bus.mem_addr  <= cur_addr;
        bus.mem_wdata <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_sa_result_writer.sv
// Self-checking bench: per-cycle compare against a transfer-level
// model plus literal address sequences for the directed cases.
module tb_sa_result_writer;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int DIM = 3;
  localparam int N   = DIM * DIM;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;

  sa_result_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sa_result_writer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DIM    (DIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Transfer-level model: active while fewer than N elements taken.
  bit            m_active;
  bit            m_fin;
  int            m_cnt;
  int            m_base;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic [AW-1:0] wlog[$];
  int            n_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_fin    = 0;
    m_cnt    = 0;
    m_base   = 0;
    m_we     = 0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic compare();
    chk("in_ready", int'(bus.in_ready), int'(m_active));
    chk("busy", int'(busy), int'(m_active | m_fin));
    chk("done", int'(done), int'(m_fin));
    chk("mem_we", int'(bus.mem_we), int'(m_we));
    chk("mem_addr", int'(bus.mem_addr), int'(m_addr));
    chk("mem_wdata", int'(bus.mem_wdata), int'(m_data));
  endtask

  // One clock: update model from the inputs seen at the edge, compare.
  task automatic step();
    bit was_active;
    bit was_fin;
    @(posedge clk);
    was_active = m_active;
    was_fin    = m_fin;
    m_we       = 0;
    if (!was_active && !was_fin && start) begin
      m_active = 1;
      m_base   = int'(base_addr);
      m_cnt    = 0;
    end
    if (was_active && bus.in_valid) begin
      m_we   = 1;
      m_addr = AW'((m_base + (m_cnt % DIM) * DIM + m_cnt / DIM) % (1 << AW));
      m_data = bus.in_data;
      m_cnt++;
      if (m_cnt == N) begin
        m_active = 0;
        m_fin    = 1;
      end
    end
    if (was_fin) m_fin = 0;
    #1;
    compare();
    if (bus.mem_we) wlog.push_back(bus.mem_addr);
    if (done) n_done++;
  endtask

  task automatic chk_log(input string nm, input int e [N]);
    chk({nm, "_count"}, wlog.size(), N);
    for (int i = 0; i < N; i++)
      if (i < wlog.size()) chk(nm, int'(wlog[i]), e[i]);
  endtask

  // mode 0: valid always; 1: 1,0,0 pattern; 2: random.
  task automatic run_mat(input int b, input int mode, input bit noise,
                         input bit hold, output int steps);
    int n;
    n = 0;
    start     = 1'b1;
    base_addr = AW'(b);
    bus.in_valid = 1'b0;
    step();
    start = 1'b0;
    while (!m_fin && n < 200) begin
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = ((n % 3) == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = (mode == 2) ? DW'($urandom) : DW'(8'h10 + m_cnt);
      if (noise) begin
        start     = 1'($urandom_range(0, 1));
        base_addr = AW'(20);
      end
      step();
      n++;
    end
    if (n >= 200) chk("transfer_timeout", n, -1);
    steps = n + 1;
    bus.in_valid = 1'b1;
    start        = hold;
    step();
  endtask

  initial begin
    int st;
    int e[N];
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    n_done       = 0;
    model_reset();
    #1;
    compare();
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back valid, base 0.
    wlog.delete();
    run_mat(0, 0, 0, 0, st);
    e = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    chk_log("seq_base0", e);
    chk("start_to_done_steps", st, 10);

    // Gapped valid.
    wlog.delete();
    n_done = 0;
    run_mat(0, 1, 0, 0, st);
    chk_log("seq_gapped", e);
    chk("gapped_done_cnt", n_done, 1);

    // Wrap-around base.
    wlog.delete();
    run_mat(60, 0, 0, 0, st);
    e = '{60, 63, 2, 61, 0, 3, 62, 1, 4};
    chk_log("seq_base60", e);

    // Valid in IDLE, start noise during WRITE.
    wlog.delete();
    bus.in_valid = 1'b1;
    repeat (3) step();
    run_mat(5, 0, 1, 0, st);
    e = '{5, 8, 11, 6, 9, 12, 7, 10, 13};
    chk_log("seq_noise", e);

    // Reset after the 4th handshake.
    start     = 1'b1;
    base_addr = AW'(33);
    step();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) step();
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
    wlog.delete();
    run_mat(9, 0, 0, 0, st);
    e = '{9, 12, 15, 10, 13, 16, 11, 14, 17};
    chk_log("seq_after_rst", e);

    // start held through DONE: two back-to-back matrices.
    wlog.delete();
    n_done = 0;
    run_mat(40, 0, 0, 1, st);
    run_mat(40, 2, 0, 0, st);
    chk("b2b_writes", wlog.size(), 2 * N);
    chk("b2b_done", n_done, 2);

    // Randomized matrices.
    for (int t = 0; t < 12; t++)
      run_mat(int'($urandom_range(0, 63)), 2, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), st);
    start = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
